// File: rtl/matrix_input_loader_if.sv
// Read port between the matrix input loader and the input RAM.
// The loader drives the address and write enable; the RAM returns read data.
interface matrix_input_loader_if #(
    parameter int MEM_PORT_WIDTH = 32
);
    logic [31:0]               mem_addr;
    logic                      mem_wr_en;
    logic [MEM_PORT_WIDTH-1:0] mem_rd_data;

    modport master (
        output mem_addr,
        output mem_wr_en,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_en,
        output mem_rd_data
    );
endinterface

// File: rtl/matrix_input_loader.sv
// Loads the top and left systolic-array operands element by element from the
// input RAM, row-major, and presents them as packed matrices until consumed.
`ifndef ROWS
`define ROWS 2
`endif
`ifndef COLS
`define COLS 2
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef MEM_ACCESS_LATENCY
`define MEM_ACCESS_LATENCY 1
`endif
`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 32
`endif

module matrix_input_loader #(
    parameter int ROWS               = `ROWS,
    parameter int COLS               = `COLS,
    parameter int WORD_SIZE          = `WORD_SIZE,
    parameter int MEM_ACCESS_LATENCY = `MEM_ACCESS_LATENCY,
    parameter int MEM_PORT_WIDTH     = `MEM_PORT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_start,
    input  logic [31:0]                     top_base_addr,
    input  logic [31:0]                     left_base_addr,
    input  logic                            consume,
    matrix_input_loader_if.master           mem,
    output logic [ROWS*COLS*WORD_SIZE-1:0]  top_matrix,
    output logic [ROWS*COLS*WORD_SIZE-1:0]  left_matrix,
    output logic                            inputs_rdy,
    output logic                            busy
);

    localparam int NUM_ELEMS = ROWS * COLS;
    localparam int MAT_W     = NUM_ELEMS * WORD_SIZE;
    localparam int K_W       = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam int LAT_W     = (MEM_ACCESS_LATENCY > 1) ? $clog2(MEM_ACCESS_LATENCY) : 1;
    localparam logic [K_W-1:0]   LAST_K   = K_W'(NUM_ELEMS - 1);
    localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(MEM_ACCESS_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        CAPTURE,
        READY
    } state_t;

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               sel_q, sel_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [31:0]        top_base_q, top_base_d;
    logic [31:0]        left_base_q, left_base_d;
    logic [31:0]        addr_q, addr_d;
    logic [MAT_W-1:0]   top_q, top_d;
    logic [MAT_W-1:0]   left_q, left_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;

    // Only the low WORD_SIZE bits of a RAM word carry an element.
    logic [MEM_PORT_WIDTH-1:0] rd_data;
    logic                      unused_rd_data;
    assign rd_data        = mem.mem_rd_data;
    assign unused_rd_data = ^rd_data;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        sel_d       = sel_q;
        lat_d       = lat_q;
        top_base_d  = top_base_q;
        left_base_d = left_base_q;
        addr_d      = addr_q;
        top_d       = top_q;
        left_d      = left_q;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    top_base_d  = top_base_addr;
                    left_base_d = left_base_addr;
                    k_d         = '0;
                    sel_d       = 1'b0;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                addr_d  = (sel_q ? left_base_q : top_base_q) + 32'(k_q);
                lat_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == LAST_LAT) begin
                    state_d = CAPTURE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            CAPTURE: begin
                if (sel_q) begin
                    left_d[k_q*WORD_SIZE +: WORD_SIZE] = rd_data[WORD_SIZE-1:0];
                end else begin
                    top_d[k_q*WORD_SIZE +: WORD_SIZE] = rd_data[WORD_SIZE-1:0];
                end
                if (k_q != LAST_K) begin
                    k_d     = k_q + 1'b1;
                    state_d = ADDR;
                end else if (!sel_q) begin
                    k_d     = '0;
                    sel_d   = 1'b1;
                    state_d = ADDR;
                end else begin
                    state_d = READY;
                end
            end
            READY: begin
                if (consume) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered alongside the state they describe.
        busy_d = (state_d == ADDR) || (state_d == WAIT) || (state_d == CAPTURE);
        rdy_d  = (state_d == READY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            sel_q       <= 1'b0;
            lat_q       <= '0;
            top_base_q  <= '0;
            left_base_q <= '0;
            addr_q      <= '0;
            top_q       <= '0;
            left_q      <= '0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            sel_q       <= sel_d;
            lat_q       <= lat_d;
            top_base_q  <= top_base_d;
            left_base_q <= left_base_d;
            addr_q      <= addr_d;
            top_q       <= top_d;
            left_q      <= left_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wr_en = 1'b0;
    assign top_matrix    = top_q;
    assign left_matrix   = left_q;
    assign inputs_rdy    = rdy_q;
    assign busy          = busy_q;

endmodule

// File: doc/matrix_input_loader.md
MATRIX_INPUT_LOADER -- requirements
Module: matrix_input_loader

Interface
REQ-001: Parameter ROWS, default `ROWS, systolic array row count.
REQ-002: Parameter COLS, default `COLS, systolic array column count.
REQ-003: Parameter WORD_SIZE, default `WORD_SIZE, matrix element width in bits.
REQ-004: Parameter MEM_ACCESS_LATENCY, default `MEM_ACCESS_LATENCY, input-RAM read latency in cycles, legal range >= 1.
REQ-005: Parameter MEM_PORT_WIDTH, default `MEM_PORT_WIDTH, input-RAM data width; SHALL be >= WORD_SIZE.
REQ-006: clk  input  1  single clock; all state on rising edge.
REQ-007: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008: load_start  input  1  one-cycle request to load both operand matrices.
REQ-009: top_base_addr  input  32  RAM word address of top-matrix element (0,0).
REQ-010: left_base_addr  input  32  RAM word address of left-matrix element (0,0).
REQ-011: consume  input  1  downstream has taken the matrices (tied to the matmul start pulse).
REQ-012: mem_rd_data  input  MEM_PORT_WIDTH  read data from input RAM.
REQ-013: mem_addr  output  32  read address to input RAM.
REQ-014: mem_wr_en  output  1  write enable to input RAM.
REQ-015: top_matrix  output  ROWS*COLS*WORD_SIZE  packed top operand.
REQ-016: left_matrix  output  ROWS*COLS*WORD_SIZE  packed left operand.
REQ-017: inputs_rdy  output  1  both matrices valid and stable.
REQ-018: busy  output  1  load in progress.

Function
REQ-019: FSM states SHALL be IDLE, ADDR, WAIT, CAPTURE, READY.
REQ-020: IDLE + load_start=1 SHALL latch both base addresses, clear element index k and matrix select (0=top), go to ADDR; load_start SHALL be ignored in every other state.
REQ-021: ADDR SHALL register mem_addr = base(select) + k, clear latency counter, go to WAIT.
REQ-022: WAIT SHALL count MEM_ACCESS_LATENCY-1 further cycles, then go to CAPTURE; with MEM_ACCESS_LATENCY=1, WAIT SHALL last exactly one cycle.
REQ-023: CAPTURE SHALL store mem_rd_data[WORD_SIZE-1:0] into bits [k*WORD_SIZE +: WORD_SIZE] of the selected matrix; upper mem_rd_data bits SHALL be discarded.
REQ-024: Element order SHALL be row-major: k = r*COLS + c holds element (r,c), for both matrices.
REQ-025: After CAPTURE, if k < ROWS*COLS-1: k++, go to ADDR; if k = ROWS*COLS-1 and select=top: k=0, select=left, go to ADDR; if k = ROWS*COLS-1 and select=left: go to READY.
REQ-026: Per-element cost SHALL be MEM_ACCESS_LATENCY+2 cycles; full load SHALL take 2*ROWS*COLS*(MEM_ACCESS_LATENCY+2) cycles from the load_start edge to inputs_rdy=1.
REQ-027: inputs_rdy SHALL be 1 only in READY; busy SHALL be 1 in ADDR, WAIT and CAPTURE.
REQ-028: READY + consume=1 SHALL go to IDLE, with inputs_rdy low next cycle; consume SHALL be ignored outside READY.
REQ-029: top_matrix/left_matrix SHALL hold their contents from READY until the next load overwrites elements; partially loaded contents SHALL NOT be flagged valid.
REQ-030: mem_wr_en SHALL be 0 in every state.
REQ-031: mem_addr SHALL hold its last value outside ADDR; 32-bit address addition SHALL wrap modulo 2^32.
REQ-032: Base-address changes after the latch cycle SHALL NOT affect an ongoing load.

Reset
REQ-033: rst=0 SHALL asynchronously force IDLE, k=0, select=top, mem_addr=0, mem_wr_en=0, inputs_rdy=0, busy=0, top_matrix=0, left_matrix=0.
REQ-034: rst asserted mid-load SHALL abort the load; no inputs_rdy pulse SHALL follow the reset release until a new load_start.

Verification
REQ-035: ROWS=COLS=2, LAT=1, WORD_SIZE=8, top_base=0x10 holding 1,2,3,4, left_base=0x20 holding 5,6,7,8 -> addresses 0x10..0x13 then 0x20..0x23, inputs_rdy at cycle 24, top_matrix=0x04030201, left_matrix=0x08070605.
REQ-036: Same as REQ-035 with LAT=3 -> inputs_rdy exactly 40 cycles after load_start; same packed values.
REQ-037: Second load_start pulsed mid-load and base addresses changed mid-load -> ignored, results identical to REQ-035.
REQ-038: In READY, hold consume=0 for 10 cycles -> inputs_rdy and matrices stable; pulse consume -> inputs_rdy=0 next cycle, state IDLE.
REQ-039: rst driven low during left-matrix load -> all outputs 0 immediately (no clock edge required); new load_start after release completes normally.
REQ-040: mem_rd_data=0xFFFFFF01 with MEM_PORT_WIDTH=32, WORD_SIZE=8 -> stored element 0x01; top_base=0xFFFFFFFF -> second address 0x00000000; mem_wr_en 0 throughout.
